// File: rtl/servo_pwm_map.sv
// servo_pwm_map: averages the last four ADC samples and maps the
// average to a fixed-period servo PWM, reloading the width only at period ends.
module servo_pwm_map #(
    parameter int PERIOD_CYC = 1_000_000,
    parameter int MIN_CYC    = 50_000,
    parameter int SPAN_CYC   = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] dato_ADC,
    input  logic        enable,
    output logic        pwm,
    output logic [19:0] ancho,
    output logic [11:0] prom,
    output logic        nuevo
);

    localparam logic [19:0] LAST   = 20'(PERIOD_CYC - 1);
    localparam logic [19:0] CENTRE = 20'(MIN_CYC + SPAN_CYC / 2);
    localparam logic [19:0] MIN_W  = 20'(MIN_CYC);
    localparam logic [28:0] SPAN_W = 29'(SPAN_CYC);

    logic        s1, s2, s3;
    logic        capture;
    logic [11:0] h0, h1, h2, h3;
    logic [13:0] sum_c;
    logic [16:0] scaled;
    logic [19:0] pend;
    logic [19:0] cnt;

    assign capture = s2 & ~s3;

    assign sum_c = {2'd0, h0} + {2'd0, h1}
                 + {2'd0, h2} + {2'd0, h3};

    // 12x17 product kept at 29 bits, then scaled back by the 12-bit ADC range
    assign scaled = 17'(({17'd0, prom} * SPAN_W) >> 12);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= enable;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h0 <= 12'h800;
            h1 <= 12'h800;
            h2 <= 12'h800;
            h3 <= 12'h800;
        end else if (capture) begin
            h0 <= dato_ADC;
            h1 <= h0;
            h2 <= h1;
            h3 <= h2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prom <= 12'h800;
            pend <= CENTRE;
        end else begin
            prom <= 12'(sum_c >> 2);
            pend <= MIN_W + {3'd0, scaled};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= 20'd0;
            ancho <= CENTRE;
            nuevo <= 1'b0;
            pwm   <= 1'b0;
        end else begin
            pwm   <= (cnt < ancho);
            nuevo <= 1'b0;
            if (cnt == LAST) begin
                cnt   <= 20'd0;
                ancho <= pend;
                nuevo <= (pend != ancho);
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_map.sv
// tb_servo_pwm_map: random and directed samples checked against a
// sample-history model of the average, mapping and per-period pulse width.
module tb_servo_pwm_map;

    localparam int P   = 1000;
    localparam int MN  = 100;
    localparam int SP  = 400;
    localparam int CTR = MN + SP / 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] dato_ADC = 12'd0;
    logic        enable = 1'b0;
    logic        pwm;
    logic [19:0] ancho;
    logic [11:0] prom;
    logic        nuevo;

    servo_pwm_map #(
        .PERIOD_CYC(P),
        .MIN_CYC   (MN),
        .SPAN_CYC  (SP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .dato_ADC(dato_ADC),
        .enable  (enable),
        .pwm     (pwm),
        .ancho   (ancho),
        .prom    (prom),
        .nuevo   (nuevo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int hist[4];
    int mc;
    int hi_acc;
    int w_cur;
    int stray;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int m_prom();
        return (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
    endfunction

    function automatic int m_pend();
        return MN + (m_prom() * SP) / 4096;
    endfunction

    function automatic int rnd_val();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return 4095;
            default: return int'($urandom_range(0, 4095));
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) hist[i] = 2048;
        mc = 0;
        hi_acc = 0;
        w_cur = CTR;
    endtask

    task automatic push(input int v);
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = v;
    endtask

    // one clock: accumulate pwm high time, check width and reload at boundaries
    task automatic tick();
        @(posedge clk);
        #1;
        hi_acc += int'(pwm);
        mc = (mc == P - 1) ? 0 : mc + 1;
        if (mc == 0) begin
            check("pwm_high", hi_acc, w_cur);
            hi_acc = 0;
            check("ancho", int'(ancho), m_pend());
            check("nuevo", int'(nuevo), int'(m_pend() != w_cur));
            w_cur = m_pend();
        end else if (nuevo) begin
            stray++;
        end
    endtask

    task automatic wait_to(input int t);
        while (mc != t) tick();
    endtask

    task automatic next_boundary();
        do tick(); while (mc != 0);
    endtask

    task automatic sample(input int v);
        enable = 1'b1;
        dato_ADC = 12'(v);
        repeat (4) tick();
        enable = 1'b0;
        repeat (4) tick();
        push(v);
        check("prom", int'(prom), m_prom());
    endtask

    task automatic hold_high(input int cycles);
        int cap;
        cap = 0;
        enable = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            dato_ADC = 12'($urandom);
            if (i == 2) cap = int'(dato_ADC);
            tick();
        end
        enable = 1'b0;
        repeat (4) tick();
        push(cap);
        check("prom_hold", int'(prom), m_prom());
    endtask

    initial begin
        stray = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm", int'(pwm), 0);
        check("rst_ancho", int'(ancho), CTR);
        check("rst_prom", int'(prom), 2048);
        check("rst_nuevo", int'(nuevo), 0);
        @(negedge clk);
        rst = 1'b1;

        next_boundary();

        wait_to(10);
        repeat (4) sample(0);
        check("prom_zero", int'(prom), 0);
        next_boundary();
        check("ancho_min", int'(ancho), MN);
        next_boundary();

        wait_to(10);
        repeat (4) sample(4095);
        check("prom_full", int'(prom), 4095);
        next_boundary();
        check("ancho_full", int'(ancho), MN + SP - 1);

        wait_to(10);
        sample(0);
        sample(0);
        sample(4095);
        sample(4095);
        check("prom_mid", int'(prom), 2047);
        next_boundary();
        check("ancho_mid", int'(ancho), MN + SP / 2 - 1);

        wait_to(10);
        hold_high(200);
        next_boundary();

        wait_to(P - 3);
        sample(hist[0] == 0 ? 4095 : 0);
        next_boundary();
        next_boundary();

        for (int p = 0; p < 15; p++) begin
            wait_to(10);
            for (int k = 0; k < int'($urandom_range(0, 4)); k++)
                sample(rnd_val());
            next_boundary();
        end

        wait_to(w_cur * 3 / 10);
        check("pre_rst_pwm", int'(pwm), 1);
        rst = 1'b0;
        #1;
        check("arst_pwm", int'(pwm), 0);
        check("arst_ancho", int'(ancho), CTR);
        check("arst_prom", int'(prom), 2048);
        check("arst_nuevo", int'(nuevo), 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        next_boundary();
        next_boundary();

        check("nuevo_stray", stray, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/servo_pwm_map.md
# servo_pwm_map

Downstream consumer of the ADC capture stage in the servo path. Takes each 12-bit ADC word and its ready flag from the slower capture clock domain and averages the last four samples. The average is mapped linearly to a servo pulse width, and the block emits a fixed-period PWM. The width is updated only at period boundaries, so no pulse is ever truncated or stretched mid-period.

## Interface
- PERIOD_CYC, 1_000_000: PWM period in clk cycles (20 ms at 50 MHz).
- MIN_CYC, 50_000: pulse width for average = 0 (1 ms).
- SPAN_CYC, 50_000: added width at full scale; requires MIN_CYC + SPAN_CYC < PERIOD_CYC.
- clk  input  1  system clock; one clock domain.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- dato_ADC  input  12  ADC sample; stable while enable is high.
- enable  input  1  sample-ready level from the capture stage; asynchronous to clk.
- pwm  output  1  servo drive.
- ancho  output  20  active pulse width in cycles.
- prom  output  12  current 4-sample average.
- nuevo  output  1  one-cycle strobe when ancho is reloaded with a changed value.

## Operation
- Synchronizer: enable passes through 3 flops (s1→s2→s3). A capture event is s2 & ~s3, i.e. a rising edge. A level held high produces exactly one capture.
- Capture: on the event, dato_ADC is shifted into a 4-entry history (h0 newest … h3). h3 is discarded.
- Average:
  - 14-bit sum of h0..h3, registered in the cycle after capture.
  - prom = sum >> 2, truncating; no rounding.
- Mapping:
  - pend = MIN_CYC + ((prom × SPAN_CYC) >> 12), registered one cycle after prom.
  - Product is 12 × 17 → 29 bits, no overflow.
  - prom = 4095 gives MIN_CYC + SPAN_CYC − 13 (rounded-down).
- Period counter: cnt counts 0..PERIOD_CYC−1 and wraps to 0.
- Reload: in the cycle where cnt = PERIOD_CYC−1, ancho <= pend.
  - nuevo pulses that same edge only if pend ≠ ancho.
- PWM: pwm = registered (cnt < ancho). It is high for exactly ancho cycles per period, starting at cnt = 0.
- Simultaneous events:
  - Capture on the reload cycle: reload uses the old pend; the new sample takes effect next period.
  - Several captures within one period: only the last pend at the boundary is applied.
- Reset values (rst low, asynchronous):
  - Counter and synchronizer flops: cnt = 0, s1/s2/s3 = 0.
  - Data path: h0..h3 = 12'h800, prom = 12'h800, pend = ancho = MIN_CYC + SPAN_CYC/2 (75_000, centre).
  - Outputs: pwm = 0, nuevo = 0.
- Reset mid-period: pwm drops immediately (asynchronous). After release, the first period starts at cnt = 0 with the centre width.

## Timing
- enable rise at clk edge k: s2 = 1 at k+2, capture at edge k+3, prom valid at k+4, pend valid at k+5.
- Latency to output: pend reaches ancho at the next boundary after k+5. Worst case is PERIOD_CYC + 5 cycles.
- pwm is a registered output, one cycle behind the cnt compare, so the high time is exactly ancho cycles.
- enable must stay low at least 2 clk cycles between samples to be seen as a new event. The capture stage's slower clock guarantees this.
- dato_ADC must be stable from the enable rise until 4 clk cycles after it.

## Test plan
- Reset release, no samples: pwm high 75_000 cycles, low 925_000; ancho = 75_000, nuevo never pulses.
- Four samples of 0, then wait for the boundary: prom = 0, ancho = 50_000, single nuevo pulse; the next period shows a pwm high time of 50_000.
- Four samples of 4095: prom = 4095, ancho = 99_987; samples 0, 0, 4095, 4095 give prom = 2047, ancho = 74_987.
- enable held high for 10_000 cycles with a changing dato_ADC: exactly one capture (value at rise + 3 cycles); history shifts once.
- Sample arrives in the cycle where cnt = PERIOD_CYC−3: the current period keeps the old width; the new width appears one period later with no runt pulse.
- rst asserted at cnt = 30_000 while pwm is high: pwm = 0 immediately, all state returns to reset values, and the first period after release is 75_000 high.
